frequency_calculator: RTL and testbench

Downstream stage of `period_counter`. Accepts a measured input period, in system-clock cycles, on the counter's completion pulse. Converts it with a sequential restoring divider to an auto-scaled frequency, mantissa × 10^exponent in millihertz, with the mantissa held to four decimal digits. Results feed the BCD/display stage.

---
 rtl/frequency_calculator_if.sv | 31 +++
 rtl/frequency_calculator.sv | 138 +++++++++++++
 tb/tb_frequency_calculator.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/frequency_calculator_if.sv
// Handshake and result bus between period_counter, frequency_calculator and the display stage.
// The master drives periods and reads results; the slave (the calculator) does the reverse.
interface frequency_calculator_if;
    logic [31:0] period_count_i;
    logic        period_valid_i;
    logic [13:0] mantissa_o;
    logic [3:0]  exponent_o;
    logic        err_o;
    logic        busy_o;
    logic        done_o;

    modport master (
        output period_count_i,
        output period_valid_i,
        input  mantissa_o,
        input  exponent_o,
        input  err_o,
        input  busy_o,
        input  done_o
    );

    modport slave (
        input  period_count_i,
        input  period_valid_i,
        output mantissa_o,
        output exponent_o,
        output err_o,
        output busy_o,
        output done_o
    );
endinterface

// File: rtl/frequency_calculator.sv
// Converts a period in clock cycles to mantissa x 10^exponent millihertz using a restoring divider.
// Define FREQ_CALC_ROUND_EN to round each divide-by-10 normalization pass instead of truncating.
module frequency_calculator #(
    parameter longint unsigned CLK_FREQ_HZ = 64'd100_000_000,
    parameter int unsigned     DIV_W       = 48
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    frequency_calculator_if.slave bus
);
    localparam longint unsigned   DIVIDEND_FULL = CLK_FREQ_HZ * 64'd1000;
    localparam logic [DIV_W-1:0]  DIVIDEND      = DIV_W'(DIVIDEND_FULL);
    localparam int unsigned       CNT_W         = $clog2(DIV_W + 1);
    localparam logic [CNT_W-1:0]  LAST_STEP     = CNT_W'(DIV_W - 1);
    localparam logic [DIV_W-1:0]  MANT_LIMIT    = DIV_W'(10000);
    localparam logic [DIV_W-1:0]  TEN           = DIV_W'(10);

    typedef enum logic [1:0] {IDLE, DIVIDE, CHECK, DONE} state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] quo_q, quo_d;
    logic [DIV_W-1:0] rem_q, rem_d;
    logic [DIV_W-1:0] divisor_q, divisor_d;
    logic [CNT_W-1:0] step_q, step_d;
    logic [3:0]       exp_q, exp_d;
    logic [13:0]      mantissa_q, mantissa_d;
    logic [3:0]       exponent_q, exponent_d;
    logic             err_q, err_d;

    logic [DIV_W:0]   shifted;
    logic [DIV_W-1:0] diff;
    logic             subOk;
    logic             roundUp;
    logic [DIV_W-1:0] quoAdj;

    assign shifted = {rem_q, quo_q[DIV_W-1]};
    assign subOk   = shifted >= {1'b0, divisor_q};
    assign diff    = shifted[DIV_W-1:0] - divisor_q;

    // Only divide-by-10 passes (exponent already non-zero) may round; the first pass always truncates.
`ifdef FREQ_CALC_ROUND_EN
    assign roundUp = (exp_q != 4'd0) && (rem_q >= DIV_W'(5));
`else
    assign roundUp = 1'b0;
`endif
    assign quoAdj = quo_q + {{(DIV_W-1){1'b0}}, roundUp};

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            quo_q      <= '0;
            rem_q      <= '0;
            divisor_q  <= '0;
            step_q     <= '0;
            exp_q      <= '0;
            mantissa_q <= '0;
            exponent_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            quo_q      <= quo_d;
            rem_q      <= rem_d;
            divisor_q  <= divisor_d;
            step_q     <= step_d;
            exp_q      <= exp_d;
            mantissa_q <= mantissa_d;
            exponent_q <= exponent_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        quo_d      = quo_q;
        rem_d      = rem_q;
        divisor_d  = divisor_q;
        step_d     = step_q;
        exp_d      = exp_q;
        mantissa_d = mantissa_q;
        exponent_d = exponent_q;
        err_d      = err_q;
        unique case (state_q)
            IDLE: begin
                if (bus.period_valid_i) begin
                    if (bus.period_count_i == 32'd0) begin
                        err_d      = 1'b1;
                        mantissa_d = '0;
                        exponent_d = '0;
                        state_d    = DONE;
                    end else begin
                        quo_d     = DIVIDEND;
                        rem_d     = '0;
                        divisor_d = {{(DIV_W-32){1'b0}}, bus.period_count_i};
                        exp_d     = '0;
                        step_d    = '0;
                        state_d   = DIVIDE;
                    end
                end
            end
            DIVIDE: begin
                quo_d  = {quo_q[DIV_W-2:0], subOk};
                rem_d  = subOk ? diff : shifted[DIV_W-1:0];
                step_d = step_q + CNT_W'(1);
                if (step_q == LAST_STEP) begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                // Too many digits: divide again by ten and bump the exponent.
                if (quoAdj >= MANT_LIMIT) begin
                    quo_d     = quoAdj;
                    rem_d     = '0;
                    divisor_d = TEN;
                    exp_d     = exp_q + 4'd1;
                    step_d    = '0;
                    state_d   = DIVIDE;
                end else begin
                    mantissa_d = quoAdj[13:0];
                    exponent_d = exp_q;
                    err_d      = 1'b0;
                    state_d    = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.mantissa_o = mantissa_q;
    assign bus.exponent_o = exponent_q;
    assign bus.err_o      = err_q;
    assign bus.busy_o     = (state_q != IDLE);
    assign bus.done_o     = (state_q == DONE);
endmodule

// File: tb/tb_frequency_calculator.sv
// Self-checking bench for frequency_calculator: directed cases plus random periods
// compared against an arithmetic reference model.
module tb_frequency_calculator;
    localparam longint unsigned CLK_HZ    = 64'd100_000_000;
    localparam int unsigned     DIV_W     = 48;
    localparam longint unsigned DIV_W_L   = 64'd48;
    localparam longint unsigned TIMEOUT   = 64'd1000;
`ifdef FREQ_CALC_ROUND_EN
    localparam longint unsigned ROUND7_M  = 64'd1429;
`else
    localparam longint unsigned ROUND7_M  = 64'd1428;
`endif

    logic            clk   = 1'b0;
    logic            reset = 1'b1;
    longint unsigned checks    = 0;
    longint unsigned errors    = 0;
    longint unsigned doneCount = 0;

    frequency_calculator_if bus();

    frequency_calculator #(.CLK_FREQ_HZ(CLK_HZ), .DIV_W(DIV_W)) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.done_o) doneCount++;
    end

    task automatic checkOutput(input string tag, input longint unsigned observed,
                               input longint unsigned expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Reference: whole division, then repeated /10 with optional per-pass rounding.
    function automatic void refModel(input longint unsigned period, output longint unsigned mant,
                                     output longint unsigned expo, output longint unsigned err,
                                     output longint unsigned lat);
        longint unsigned q;
        if (period == 0) begin
            mant = 0; expo = 0; err = 1; lat = 1;
            return;
        end
        q    = (CLK_HZ * 64'd1000) / period;
        expo = 0;
        while (q >= 64'd10000) begin
`ifdef FREQ_CALC_ROUND_EN
            if (q % 64'd10 >= 64'd5) q = q / 64'd10 + 64'd1;
            else q = q / 64'd10;
`else
            q = q / 64'd10;
`endif
            expo++;
        end
        mant = q;
        err  = 0;
        lat  = 64'd1 + (expo + 64'd1) * (DIV_W_L + 64'd1);
    endfunction

    task automatic applyStimulus(input string tag, input logic [31:0] period,
                                 output longint unsigned latency);
        @(negedge clk);
        bus.period_count_i = period;
        bus.period_valid_i = 1'b1;
        @(posedge clk);
        #1;
        bus.period_valid_i = 1'b0;
        checkOutput({tag, "_busy_rise"}, longint'(bus.busy_o), 1);
        latency = 1;
        while (!bus.done_o && latency <= TIMEOUT) begin
            @(posedge clk);
            #1;
            latency++;
        end
    endtask

    task automatic runJob(input string tag, input logic [31:0] period,
                          output longint unsigned latency);
        longint unsigned m, e, er, expLat;
        applyStimulus(tag, period, latency);
        refModel(longint'(period), m, e, er, expLat);
        checkOutput({tag, "_latency"}, latency, expLat);
        checkOutput({tag, "_mantissa"}, longint'(bus.mantissa_o), m);
        checkOutput({tag, "_exponent"}, longint'(bus.exponent_o), e);
        checkOutput({tag, "_err"}, longint'(bus.err_o), er);
        @(posedge clk);
        #1;
        checkOutput({tag, "_done_pulse"}, longint'(bus.done_o), 0);
        checkOutput({tag, "_busy_fall"}, longint'(bus.busy_o), 0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput({tag, "_hold"}, longint'(bus.mantissa_o), m);
    endtask

    initial begin
        longint unsigned lat;
        longint unsigned startDone;
        logic [31:0]     period;

        bus.period_count_i = '0;
        bus.period_valid_i = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("reset_mantissa", longint'(bus.mantissa_o), 0);
        checkOutput("reset_exponent", longint'(bus.exponent_o), 0);
        checkOutput("reset_err", longint'(bus.err_o), 0);
        checkOutput("reset_busy", longint'(bus.busy_o), 0);
        checkOutput("reset_done", longint'(bus.done_o), 0);

        runJob("hz1", 32'd100_000_000, lat);
        checkOutput("hz1_const_latency", lat, 50);
        checkOutput("hz1_const_mantissa", longint'(bus.mantissa_o), 1000);
        checkOutput("hz1_const_exponent", longint'(bus.exponent_o), 0);

        runJob("p250", 32'd250, lat);
        checkOutput("p250_const_latency", lat, 295);
        checkOutput("p250_const_mantissa", longint'(bus.mantissa_o), 4000);
        checkOutput("p250_const_exponent", longint'(bus.exponent_o), 5);

        runJob("p7", 32'd7, lat);
        checkOutput("p7_const_mantissa", longint'(bus.mantissa_o), ROUND7_M);
        checkOutput("p7_const_exponent", longint'(bus.exponent_o), 7);

        runJob("zero", 32'd0, lat);
        checkOutput("zero_const_latency", lat, 1);
        checkOutput("zero_const_err", longint'(bus.err_o), 1);

        runJob("p1", 32'd1, lat);
        checkOutput("p1_const_exponent", longint'(bus.exponent_o), 8);

        // Hold period_valid_i high for the whole job, DONE cycle included.
        startDone = doneCount;
        @(negedge clk);
        bus.period_count_i = 32'd5;
        bus.period_valid_i = 1'b1;
        @(posedge clk);
        #1;
        bus.period_count_i = 32'd3;
        lat = 1;
        while (!bus.done_o && lat <= TIMEOUT) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput("busy_ignore_latency", lat, 393);
        @(posedge clk);
        #1;
        bus.period_valid_i = 1'b0;
        checkOutput("busy_ignore_idle", longint'(bus.busy_o), 0);
        repeat (5) @(posedge clk);
        #1;
        checkOutput("busy_ignore_busy", longint'(bus.busy_o), 0);
        checkOutput("busy_ignore_done_count", doneCount - startDone, 1);
        checkOutput("busy_ignore_mantissa", longint'(bus.mantissa_o), 2000);
        checkOutput("busy_ignore_exponent", longint'(bus.exponent_o), 7);

        @(negedge clk);
        bus.period_count_i = 32'd12345;
        bus.period_valid_i = 1'b1;
        @(posedge clk);
        #1;
        bus.period_valid_i = 1'b0;
        repeat (20) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        startDone = doneCount;
        checkOutput("midreset_busy", longint'(bus.busy_o), 0);
        checkOutput("midreset_mantissa", longint'(bus.mantissa_o), 0);
        checkOutput("midreset_exponent", longint'(bus.exponent_o), 0);
        checkOutput("midreset_err", longint'(bus.err_o), 0);
        checkOutput("midreset_done", longint'(bus.done_o), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        checkOutput("midreset_no_done", doneCount - startDone, 0);
        runJob("after_reset", 32'd12345, lat);

        for (int i = 0; i < 12; i++) begin
            case (i % 4)
                0: period = 32'($urandom_range(1, 20));
                1: period = 32'($urandom_range(21, 100_000));
                2: period = 32'($urandom_range(100_001, 200_000_000));
                default: period = $urandom;
            endcase
            runJob($sformatf("rand%0d", i), period, lat);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
